// File: rtl/movement_sequencer.sv
// -----------------------------------------------------------------------------
// movement_sequencer
//
// Purpose:
//   Steps the dog toy through a fixed movement routine
//   (FORWARD, TURN_LEFT, FORWARD, TURN_RIGHT, SIT, then back to FORWARD).
//   Each step is held for DWELL cycles. While moving forward, a synchronised
//   obstacle input triggers an avoidance manoeuvre: BACKWARD for BACK_TIME
//   cycles, then TURN_RIGHT for DWELL cycles, then a full FORWARD step at the
//   same routine position.
//
// Parameters:
//   DWELL      cycles each routine step (and the avoidance turn) is held, >= 2
//   BACK_TIME  cycles BACKWARD is held during avoidance, >= 2
//   CNT_W      dwell counter width, 2**CNT_W > max(DWELL, BACK_TIME)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   start      synchronous pulse, begins the routine from IDLE
//   stop       synchronous pulse, returns to IDLE from any state (wins over start)
//   obstacle   asynchronous level from the front sensor, high = obstacle
//   bit0..2    movement code {bit0,bit1,bit2}, bit0 is the MSB
//   running    high in every state except IDLE
//   step_done  one-cycle pulse, high in the first cycle after each dwell expiry
//
// Movement codes {bit0,bit1,bit2}:
//   IDLE 000, FORWARD 001, BACKWARD 010, TURN_LEFT 011, TURN_RIGHT 100, SIT 101
//
// The state register is exposed to checkers through the signal 'state'
// (type state_t); the routine position is 'idx' and the dwell count is 'cnt'.
// -----------------------------------------------------------------------------
module movement_sequencer #(
    parameter int DWELL     = 50_000_000,
    parameter int BACK_TIME = 25_000_000,
    parameter int CNT_W     = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    input  logic obstacle,
    output logic bit0,
    output logic bit1,
    output logic bit2,
    output logic running,
    output logic step_done
);

    // S_AVOID_RIGHT shows the same code as S_TURN_RIGHT but returns to
    // FORWARD at the saved routine index instead of advancing the routine.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FORWARD     = 3'd1,
        S_BACKWARD    = 3'd2,
        S_TURN_LEFT   = 3'd3,
        S_TURN_RIGHT  = 3'd4,
        S_SIT         = 3'd5,
        S_AVOID_RIGHT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(BACK_TIME - 1);
    localparam logic [2:0]       IDX_LAST   = 3'd4;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       idx;
    logic [2:0]       idx_n;
    logic             step_n;
    logic             obs_meta;
    logic             obs_s;
    logic [2:0]       code;

    // Routine position to movement state.
    function automatic state_t routine_state(input logic [2:0] i);
        state_t s;
        case (i)
            3'd0:    s = S_FORWARD;
            3'd1:    s = S_TURN_LEFT;
            3'd2:    s = S_FORWARD;
            3'd3:    s = S_TURN_RIGHT;
            3'd4:    s = S_SIT;
            default: s = S_FORWARD;
        endcase
        return s;
    endfunction

    // Two-flop synchroniser for the asynchronous sensor level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obs_meta <= 1'b0;
            obs_s    <= 1'b0;
        end else begin
            obs_meta <= obstacle;
            obs_s    <= obs_meta;
        end
    end

    // State, counter, index and step_done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            step_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            step_done <= step_n;
        end
    end

    // Next-state logic. Every branch either clears the counter on a state
    // change or increments it, and the increment only happens below the
    // terminal count, so the counter can never wrap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        step_n  = 1'b0;

        if (state == S_IDLE) begin
            cnt_n = '0;
            idx_n = '0;
            if (start && !stop) begin
                state_n = S_FORWARD;
            end
        end else if (stop) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                S_FORWARD: begin
                    // Obstacle beats a dwell expiry in the same cycle.
                    if (obs_s) begin
                        state_n = S_BACKWARD;
                        cnt_n   = '0;
                    end else if (cnt == DWELL_LAST) begin
                        idx_n   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                        state_n = routine_state(idx_n);
                        cnt_n   = '0;
                        step_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                S_TURN_LEFT, S_TURN_RIGHT, S_SIT: begin
                    if (cnt == DWELL_LAST) begin
                        idx_n   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                        state_n = routine_state(idx_n);
                        cnt_n   = '0;
                        step_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                S_BACKWARD: begin
                    if (cnt == BACK_LAST) begin
                        state_n = S_AVOID_RIGHT;
                        cnt_n   = '0;
                        step_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                S_AVOID_RIGHT: begin
                    // Index was kept during avoidance, so this FORWARD step
                    // is the same routine position and runs in full.
                    if (cnt == DWELL_LAST) begin
                        state_n = S_FORWARD;
                        cnt_n   = '0;
                        step_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end

                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // Output decode straight from the state register: no path from the
    // inputs, so the code only changes on a clock edge or on reset.
    always_comb begin
        code = 3'b000;
        case (state)
            S_IDLE:        code = 3'b000;
            S_FORWARD:     code = 3'b001;
            S_BACKWARD:    code = 3'b010;
            S_TURN_LEFT:   code = 3'b011;
            S_TURN_RIGHT:  code = 3'b100;
            S_AVOID_RIGHT: code = 3'b100;
            S_SIT:         code = 3'b101;
            default:       code = 3'b000;
        endcase
    end

    assign bit0    = code[2];
    assign bit1    = code[1];
    assign bit2    = code[0];
    assign running = (state != S_IDLE);

endmodule

// File: tb/tb_movement_sequencer.sv
// -----------------------------------------------------------------------------
// tb_movement_sequencer
//
// Drives movement_sequencer with DWELL=4, BACK_TIME=3 from a table of
// segments {start, stop, obstacle, cycles, code, running, step_done-first}.
// Inputs of a segment are applied for its edges (start/stop only on the
// first edge); after each edge the expected output is pushed to exp_q and
// the monitor pops and compares it on the following falling edge.
// The asynchronous reset cases are hand-written between two table runs.
// -----------------------------------------------------------------------------
module tb_movement_sequencer;

  localparam int DWELL     = 4;
  localparam int BACK_TIME = 3;
  localparam int CNT_W     = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic stop = 1'b0;
  logic obstacle = 1'b0;
  logic bit0, bit1, bit2, running, step_done;

  movement_sequencer #(
    .DWELL(DWELL),
    .BACK_TIME(BACK_TIME),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(rst),
    .start(start),
    .stop(stop),
    .obstacle(obstacle),
    .bit0(bit0),
    .bit1(bit1),
    .bit2(bit2),
    .running(running),
    .step_done(step_done)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       obs;
    int         n;
    logic [2:0] code;
    logic       run;
    logic       sd;
  } row_t;

  row_t rows[$];
  logic [4:0] exp_q[$];   // {code, running, step_done}
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  function automatic void add(input logic st, input logic sp, input logic ob, input int n,
                              input logic [2:0] code, input logic run, input logic sd);
    row_t r;
    r.start = st; r.stop = sp; r.obs = ob; r.n = n;
    r.code = code; r.run = run; r.sd = sd;
    rows.push_back(r);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bit0, bit1, bit2, running, step_done};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL seq_cycle_%0d code/run/step_done: got %b/%b/%b expected %b/%b/%b",
                 cyc, g[4:2], g[1], g[0], e[4:2], e[1], e[0]);
      end
      cyc++;
    end
  end

  task automatic check_out(input string name, input logic [4:0] e);
    logic [4:0] g;
    g = {bit0, bit1, bit2, running, step_done};
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s code/run/step_done: got %b/%b/%b expected %b/%b/%b",
               name, g[4:2], g[1], g[0], e[4:2], e[1], e[0]);
    end
  endtask

  // driver
  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      for (int j = 0; j < rows[r].n; j++) begin
        start    = (j == 0) ? rows[r].start : 1'b0;
        stop     = (j == 0) ? rows[r].stop : 1'b0;
        obstacle = rows[r].obs;
        @(posedge clk);
        #1;
        exp_q.push_back({rows[r].code, rows[r].run, rows[r].sd && (j == 0)});
      end
    end
    start    = 1'b0;
    stop     = 1'b0;
    obstacle = 1'b0;
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
  endtask

  initial begin
    int split;

    // idle, with obstacle pulses that must have no effect
    add(0, 0, 1, 3, 3'b000, 0, 0);
    add(0, 0, 0, 2, 3'b000, 0, 0);
    // full routine and wrap; obstacle pulses in TURN_LEFT and SIT
    add(1, 0, 0, 4, 3'b001, 1, 0);
    add(0, 0, 1, 2, 3'b011, 1, 1);
    add(0, 0, 0, 2, 3'b011, 1, 0);
    add(1, 0, 0, 4, 3'b001, 1, 1);  // start while running is ignored
    add(0, 0, 0, 4, 3'b100, 1, 1);
    add(0, 0, 1, 2, 3'b101, 1, 1);
    add(0, 0, 0, 2, 3'b101, 1, 0);
    add(0, 0, 0, 4, 3'b001, 1, 1);  // wrap to index 0
    add(0, 0, 0, 4, 3'b011, 1, 1);
    add(0, 0, 0, 4, 3'b001, 1, 1);
    add(0, 0, 0, 4, 3'b100, 1, 1);
    add(0, 0, 0, 2, 3'b101, 1, 1);
    add(0, 1, 0, 1, 3'b000, 0, 0);  // stop during SIT
    add(0, 0, 0, 2, 3'b000, 0, 0);
    add(1, 0, 0, 2, 3'b001, 1, 0);
    add(1, 1, 0, 1, 3'b000, 0, 0);  // stop and start together: stop wins
    add(0, 0, 0, 1, 3'b000, 0, 0);
    // single obstacle during FORWARD, coinciding with its dwell expiry
    add(1, 0, 0, 2, 3'b001, 1, 0);
    add(0, 0, 1, 2, 3'b001, 1, 0);
    add(0, 0, 0, 3, 3'b010, 1, 0);
    add(0, 0, 0, 4, 3'b100, 1, 1);
    add(0, 0, 0, 4, 3'b001, 1, 1);  // full FORWARD at saved index 0
    add(0, 0, 0, 1, 3'b011, 1, 1);
    add(0, 1, 0, 1, 3'b000, 0, 0);
    // obstacle held high
    add(1, 0, 1, 2, 3'b001, 1, 0);
    add(0, 0, 1, 3, 3'b010, 1, 0);
    add(0, 0, 1, 4, 3'b100, 1, 1);
    add(0, 0, 1, 1, 3'b001, 1, 1);
    add(0, 0, 1, 3, 3'b010, 1, 0);
    add(0, 0, 1, 4, 3'b100, 1, 1);
    add(0, 0, 1, 1, 3'b001, 1, 1);
    add(0, 1, 0, 1, 3'b000, 0, 0);
    add(0, 0, 0, 2, 3'b000, 0, 0);
    // run into TURN_LEFT for the asynchronous reset
    add(1, 0, 0, 4, 3'b001, 1, 0);
    add(0, 0, 0, 2, 3'b011, 1, 1);
    split = rows.size();
    // after reset: restart only on a new start, from index 0
    add(0, 0, 0, 2, 3'b000, 0, 0);
    add(1, 0, 0, 4, 3'b001, 1, 0);
    add(0, 0, 0, 1, 3'b011, 1, 1);
    add(0, 1, 0, 1, 3'b000, 0, 0);

    // reset values while reset is held
    #3;
    check_out("reset_values", 5'b000_0_0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_held_over_edges", 5'b000_0_0);
    rst = 1'b0;

    run_rows(0, split);

    // asynchronous reset between edges in the middle of TURN_LEFT
    #2;
    check_out("pre_reset_turn_left", 5'b011_1_0);
    rst = 1'b1;
    #1;
    check_out("async_reset_immediate", 5'b000_0_0);
    @(posedge clk);
    #1;
    check_out("async_reset_held", 5'b000_0_0);
    #2;
    rst = 1'b0;

    run_rows(split, rows.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/movement_sequencer.md
# movement_sequencer

Movement sequencer for the automatic dog toy: a single-clock FSM that steps through a fixed movement routine, holds each movement for a programmable dwell time and interrupts forward motion with an obstacle-avoidance manoeuvre. It is the producer of the 3-bit movement code (bit0 = MSB) that the seven-segment display decoder consumes, and it drives that decoder directly.

## Interface
- DWELL, 50_000_000: cycles each routine step is held (1 s at 50 MHz); must be ≥ 2
- BACK_TIME, 25_000_000: cycles BACKWARD is held during avoidance; must be ≥ 2
- CNT_W, 26: dwell counter width; must satisfy 2^CNT_W > max(DWELL, BACK_TIME)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start  in  1  synchronous pulse, begins routine from IDLE
- stop  in  1  synchronous pulse, aborts to IDLE from any state
- obstacle  in  1  asynchronous level from front sensor, high = obstacle
- bit0  out  1  movement code MSB
- bit1  out  1  movement code middle bit
- bit2  out  1  movement code LSB
- running  out  1  high in every state except IDLE
- step_done  out  1  one-cycle pulse on each dwell expiry

## Operation
- Codes {bit0,bit1,bit2}: IDLE 000, FORWARD 001, BACKWARD 010, TURN_LEFT 011, TURN_RIGHT 100, SIT 101; 110/111 never emitted.
- All outputs registered; code bits are a direct function of the state register.
- Routine index 0..4: FORWARD, TURN_LEFT, FORWARD, TURN_RIGHT, SIT; wraps 4 → 0 indefinitely.
- IDLE: counter held at 0, index held at 0; start → FORWARD (index 0).
- Routine states: counter increments each cycle; on count == DWELL-1, advance index, enter next state, clear counter, pulse step_done.
- Obstacle: 2-flop synchronizer (obs_s). In FORWARD with obs_s = 1 → BACKWARD, counter cleared, index kept; takes priority over dwell expiry in the same cycle (no step_done).
- BACKWARD: held BACK_TIME cycles, then TURN_RIGHT (avoid) for DWELL cycles, then FORWARD with counter cleared at the saved index (that FORWARD step restarts in full). step_done pulses on both expiries.
- Avoidance TURN_RIGHT is a distinct internal state (same code 100) so it returns to FORWARD rather than advancing the routine.
- obs_s ignored outside FORWARD; if still high on return to FORWARD, BACKWARD re-enters the next cycle.
- stop: from any non-IDLE state → IDLE, counter and index cleared, no step_done. stop and start in the same cycle: stop wins. start while running: ignored.

## Timing
- Reset values: code 000, running 0, step_done 0, counter 0, index 0, synchronizer flops 0.
- Reset mid-routine: outputs go to reset values immediately (asynchronous), no glitch to other codes; routine restarts only on a new start.
- start sampled at edge N → code 001 and running = 1 after edge N (visible in cycle N+1).
- Each routine step visible exactly DWELL cycles; step_done high in the first cycle of the new code.
- obstacle rising, setup-met before edge k → obs_s high after edge k+1 → code 010 after edge k+2.
- stop sampled at edge N → code 000, running 0 after edge N.
- Counter never exceeds max(DWELL, BACK_TIME)-1; no wrap-around of the counter.

## Test plan
- DWELL=4, BACK_TIME=3. Reset, then start pulse at edge 10 → codes 001 (cycles 11-14), 011 (15-18), 001 (19-22), 100 (23-26), 101 (27-30), 001 at 31; step_done high only at 15, 19, 23, 27, 31.
- Obstacle raised before edge 12 during first FORWARD → 010 from cycle 15 for 3 cycles, 100 for 4 cycles, then 001 for a full 4 cycles, then 011; index unchanged.
- Obstacle held high continuously → repeating 010×3, 100×4, 001×1, no TURN_LEFT ever reached; running stays 1.
- stop during SIT and stop+start in the same cycle → 000 next cycle, running 0, no step_done; a later start resumes at FORWARD index 0.
- Asynchronous reset asserted mid-TURN_LEFT between clock edges → outputs 000/0/0 immediately; start while running ignored (code sequence unaffected).
- Obstacle pulses during TURN_LEFT/SIT/IDLE → no effect on code sequence.
